// File: rtl/mem_arb_pkg.sv
// Types shared by the memory arbiter: FSM states and grant identifiers.
// Pure type/constant package; no logic, no latency, no backpressure.
// Feature macro ARB_ROUND_ROBIN_EN changes how these grants are chosen, not the types.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/arb_pick.sv
// Winner selector between instruction and data requesters (ARB_ROUND_ROBIN_EN selects alternation).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  gnt_t last_gnt,
  output logic gnt_vld,
  output gnt_t gnt
);

  assign gnt_vld = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = GNT_I;
    if (i_req && d_req) begin
      // On contention hand the grant to whoever did not win last time.
      gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign gnt = d_req ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access (ARB_ROUND_ROBIN_EN: alternate on contention).
// Latency: m_req one cycle after the request, x_valid one cycle after m_valid.
// Backpressure: requests are held off while a transaction is in flight (BUSY/RESP).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we_re,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we_re,
  output logic [3:0]        m_mask,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t state;
  gnt_t   gnt_q;
  gnt_t   pick_gnt;
  gnt_t   pick_last;
  logic   pick_vld;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_last = gnt_q;
`else
  assign pick_last = GNT_I;
`endif

  arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_gnt (pick_last),
    .gnt_vld  (pick_vld),
    .gnt      (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_q   <= GNT_I;
      m_req   <= 1'b0;
      m_we_re <= 1'b0;
      m_mask  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_valid <= 1'b0;
      i_rdata <= '0;
      d_valid <= 1'b0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_q <= pick_gnt;
            m_req <= 1'b1;
            state <= BUSY;
            if (pick_gnt == GNT_D) begin
              m_we_re <= d_we_re;
              m_mask  <= d_mask;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              // Fetches are always full-word reads.
              m_we_re <= 1'b0;
              m_mask  <= MASK_ALL;
              m_addr  <= i_addr;
              m_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (m_valid) begin
            m_req <= 1'b0;
            state <= RESP;
            if (gnt_q == GNT_D) begin
              d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          i_valid <= 1'b0;
          d_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we_re = 1'b0;
  logic [3:0]  d_mask = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we_re;
  logic [3:0]  m_mask;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we_re(m_we_re), .m_mask(m_mask), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: one outstanding memory transaction, then one response cycle.
  bit          mo_open  = 1'b0;
  bit          mo_pulse = 1'b0;
  bit          mo_who   = 1'b0;   // 1 = data requester
  bit          mo_last  = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ird = '0, e_drd = '0;
  logic [3:0]  e_mask = '0;
  bit          e_we = 1'b0;

  function automatic bit pick_d(input bit ir, input bit dr, input bit last_d);
`ifdef ARB_ROUND_ROBIN_EN
    if (ir && dr) return !last_d;
`endif
    return dr;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mo_open = 0; mo_pulse = 0; mo_who = 0; mo_last = 0;
      e_ird = '0; e_drd = '0;
    end else if (mo_pulse) begin
      mo_pulse = 0;
    end else if (mo_open) begin
      if (m_valid) begin
        mo_open  = 0;
        mo_pulse = 1;
        if (mo_who) e_drd = m_rdata;
        else        e_ird = m_rdata;
      end
    end else if (i_req || d_req) begin
      mo_who  = pick_d(i_req, d_req, mo_last);
      mo_last = mo_who;
      mo_open = 1;
      if (mo_who) begin
        e_addr = d_addr; e_we = d_we_re; e_mask = d_mask; e_wdata = d_wdata;
      end else begin
        e_addr = i_addr; e_we = 0; e_mask = 4'b1111; e_wdata = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_req",   32'(m_req),   32'(mo_open));
    chk("i_valid", 32'(i_valid), 32'(mo_pulse && !mo_who));
    chk("d_valid", 32'(d_valid), 32'(mo_pulse && mo_who));
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    if (mo_open) begin
      chk("m_addr",  m_addr,  e_addr);
      chk("m_we_re", 32'(m_we_re), 32'(e_we));
      chk("m_mask",  32'(m_mask),  32'(e_mask));
      chk("m_wdata", m_wdata, e_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for m_req, answers after 'delay' extra cycles, returns in the response cycle.
  task automatic serve(input int delay, input logic [31:0] rd, output int who, output int lat,
                       output logic [31:0] addr_seen, output logic we_seen);
    int n;
    n = 0;
    while (!m_req && n < 20) begin
      tick();
      n++;
    end
    lat = n;
    addr_seen = m_addr;
    we_seen = m_we_re;
    chk("m_req_rise", 32'(m_req), 32'd1);
    if (!m_req) begin
      who = -1;
      return;
    end
    repeat (delay) tick();
    m_valid = 1'b1;
    m_rdata = rd;
    tick();
    m_valid = 1'b0;
    m_rdata = 32'h0BAD_0BAD;
    if (d_valid && !i_valid)      who = 1;
    else if (i_valid && !d_valid) who = 0;
    else                          who = -1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int who, lat, exp2;
    logic [31:0] a;
    logic we;

    repeat (3) tick();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_i_valid", 32'(i_valid), 32'd0);
    rst = 1'b1;
    tick();

    // Instruction fetch at minimum latency.
    i_req = 1'b1; i_addr = 32'h100;
    serve(0, 32'h00500093, who, lat, a, we);
    chk("t1_lat", 32'(lat), 32'd1);
    chk("t1_who", 32'(who), 32'd0);
    chk("t1_addr", a, 32'h100);
    chk("t1_we", 32'(we), 32'd0);
    chk("t1_rdata", i_rdata, 32'h00500093);
    i_req = 1'b0;
    tick();

    // Data store.
    d_req = 1'b1; d_we_re = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_mask = 4'b0011;
    serve(0, 32'h0, who, lat, a, we);
    chk("t2_who", 32'(who), 32'd1);
    chk("t2_addr", a, 32'h2000);
    chk("t2_we", 32'(we), 32'd1);
    chk("t2_m_mask", 32'(m_mask), 32'h3);
    chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("t2_i_valid", 32'(i_valid), 32'd0);
    d_req = 1'b0; d_we_re = 1'b0;
    tick();
    chk("t2_pulse_end", 32'(d_valid), 32'd0);

    // Slow memory: five wait cycles.
    i_req = 1'b1; i_addr = 32'h300;
    serve(5, 32'hA5A5_1234, who, lat, a, we);
    chk("t3_who", 32'(who), 32'd0);
    chk("t3_rdata", i_rdata, 32'hA5A5_1234);
    i_req = 1'b0;
    tick();

    // Contention, three transactions back to back.
`ifdef ARB_ROUND_ROBIN_EN
    exp2 = 0;
`else
    exp2 = 1;
`endif
    i_req = 1'b1; i_addr = 32'h440;
    d_req = 1'b1; d_addr = 32'h4D0; d_wdata = 32'h1111_2222; d_mask = 4'b1100; d_we_re = 1'b0;
    serve(0, 32'hD0D0_0001, who, lat, a, we);
    chk("t4_first_who", 32'(who), 32'd1);
    chk("t4_first_drdata", d_rdata, 32'hD0D0_0001);
    serve(1, 32'hC0C0_0002, who, lat, a, we);
    chk("t4_second_who", 32'(who), 32'(exp2));
    if (exp2 == 1) d_req = 1'b0;
    else           i_req = 1'b0;
    serve(0, 32'hE0E0_0003, who, lat, a, we);
    chk("t4_third_who", 32'(who), 32'(1 - exp2));
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Stray m_valid in IDLE.
    m_valid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    m_valid = 1'b0;
    tick();
    chk("t5_m_req_idle", 32'(m_req), 32'd0);
    i_req = 1'b1; i_addr = 32'h380;
    serve(0, 32'h0000_5A5A, who, lat, a, we);
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_rdata", i_rdata, 32'h0000_5A5A);
    i_req = 1'b0;
    tick();

    // Reset during BUSY.
    i_req = 1'b1; i_addr = 32'h400;
    tick();
    chk("t6_busy", 32'(m_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_m_req", 32'(m_req), 32'd0);
    chk("t6_async_m_addr", m_addr, 32'd0);
    chk("t6_async_i_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("t6_no_stale", 32'(i_valid), 32'd0);
    i_req = 1'b1; i_addr = 32'h500;
    serve(2, 32'h0BEE_F000, who, lat, a, we);
    chk("t6_who", 32'(who), 32'd0);
    chk("t6_addr", a, 32'h500);
    chk("t6_rdata", i_rdata, 32'h0BEE_F000);
    i_req = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of all ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 i_req  input  1  instruction-fetch request; held until i_valid.
REQ-006 i_addr  input  ADDR_W  instruction-fetch address.
REQ-007 i_valid  output  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  output  DATA_W  fetched instruction; valid while i_valid=1.
REQ-009 d_req  input  1  data request; held until d_valid.
REQ-010 d_we_re  input  1  1=store, 0=load.
REQ-011 d_mask  input  4  byte mask.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_valid  output  1  one-cycle data completion pulse.
REQ-015 d_rdata  output  DATA_W  load data; valid while d_valid=1.
REQ-016 m_req, m_we_re  output  1 each  shared memory request and direction.
REQ-017 m_mask  output  4  shared memory byte mask.
REQ-018 m_addr, m_wdata  output  ADDR_W, DATA_W  shared memory address and write data.
REQ-019 m_valid  input  1  memory completion.
REQ-020 m_rdata  input  DATA_W  memory read data, sampled when m_valid=1.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-022 IDLE: if any request is pending, register the winner's fields into m_*, set m_req=1 and go to BUSY; otherwise stay in IDLE.
REQ-023 Fixed priority SHALL apply: d_req wins over i_req when both are asserted in the same cycle.
REQ-024 An instruction grant SHALL drive m_we_re=0 and m_mask=4'b1111; m_wdata SHALL be 0.
REQ-025 BUSY: m_* SHALL be held stable; on m_valid=1, capture m_rdata, drop m_req and go to RESP.
REQ-026 RESP: pulse the granted requester's valid for exactly one cycle with the captured rdata, then go to IDLE.
REQ-027 Requests SHALL be ignored in BUSY and RESP; a requester's req is not sampled in the cycle its valid is asserted.
REQ-028 Minimum latency SHALL be req at cycle N, m_req at N+1, x_valid at N+2 when m_valid returns at N+1.
REQ-029 m_valid SHALL be ignored in IDLE and RESP.
REQ-030 A requester that drops req during BUSY SHALL still receive its valid pulse.
REQ-031 The non-granted requester's valid SHALL remain 0, and both rdata outputs SHALL hold their last value.

Reset
REQ-032 rst=0 SHALL immediately force IDLE and set m_req=0, i_valid=0, d_valid=0, all data/address outputs to 0, and the grant pointer to instruction.
REQ-033 Reset asserted mid-transaction SHALL abandon it; no valid pulse is issued after release.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; a single request is granted regardless.
REQ-035 Without ARB_ROUND_ROBIN_EN, REQ-023 fixed priority SHALL apply and the grant pointer SHALL be absent.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/RESP) and the grant enum (GNT_I/GNT_D).
REQ-037 One sub-module, arb_pick, SHALL be used: a combinational winner selector taking i_req, d_req and the last grant.

Verification
REQ-038 i_req=1, i_addr=0x100, m_valid one cycle after m_req, m_rdata=0x00500093 -> m_addr=0x100, m_we_re=0, i_valid pulse at N+2, i_rdata=0x00500093.
REQ-039 d_req=1, d_we_re=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_mask=4'b0011 -> m_* match these values, d_valid is a single pulse, i_valid stays 0.
REQ-040 i_req and d_req asserted together for two back-to-back transactions -> fixed mode: D, D; with ARB_ROUND_ROBIN_EN: D, I.
REQ-041 m_valid delayed 5 cycles -> m_req and m_addr are stable for all 5 cycles, and exactly one valid pulse follows.
REQ-042 rst=0 during BUSY, then released -> outputs are 0 asynchronously, there is no stale valid, and the next i_req is served normally.
REQ-043 m_valid=1 pulsed in IDLE with no request -> no valid pulse and no state change.
